sel_pipe_reg: RTL and testbench

SEL_PIPE_REG -- requirements
Module: sel_pipe_reg

---
 rtl/sel_pipe_reg.sv | 127 ++++++++++++
 tb/tb_sel_pipe_reg.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sel_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : sel_pipe_reg
// Description : Registered N-to-1 channel selector with valid/ready handshake.
//               Selects channel `sel` of in_bus (zero when sel >= NUM_IN),
//               registers it with one cycle latency, supports stall, flush
//               and a sticky out-of-range-select flag.
//               Optional one-entry skid buffer enabled by defining the macro
//               SEL_PIPE_REG_SKID_EN; in that build in_ready has no
//               combinational path from out_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module sel_pipe_reg #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic                    flush,
    output logic                    sel_err
);

    // NUM_IN expressed one bit wider than sel so NUM_IN == 2**SEL_W fits
    localparam logic [SEL_W:0] c_NUM_IN_EXT = (SEL_W + 1)'(NUM_IN);

    logic [WIDTH-1:0] w_sel_word;
    logic             w_sel_oob;
    logic             w_in_ready;
    logic             w_accept;

    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_sel_err;

    // Channel multiplexer; out-of-range selects yield an all-zero word
    always_comb begin
        w_sel_word = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                w_sel_word = in_bus[k*WIDTH +: WIDTH];
            end
        end
        w_sel_oob = ({1'b0, sel} >= c_NUM_IN_EXT);
    end

    assign w_accept = in_valid && w_in_ready;

`ifdef SEL_PIPE_REG_SKID_EN
    logic [WIDTH-1:0] r_skid_data;
    logic             r_skid_valid;
    logic             w_out_free;

    // Ready depends only on skid occupancy, so out_ready never reaches in_ready
    assign w_in_ready = !r_skid_valid && !flush;
    assign w_out_free = !r_out_valid || out_ready;

    // Output and skid stages: skid drains first so word order is preserved
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_skid_data  <= '0;
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                r_out_data   <= r_skid_data;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_out_data  <= w_sel_word;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_accept) begin
            // Output stalled: park the accepted word in the skid entry
            r_skid_data  <= w_sel_word;
            r_skid_valid <= 1'b1;
        end
    end
`else
    // Accept whenever the output register is empty or draining this cycle
    assign w_in_ready = (!r_out_valid || out_ready) && !flush;

    // Single output register; data only moves on an input transfer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_data  <= w_sel_word;
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end
`endif

    // Sticky error flag: only reset clears it, flush leaves it alone
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel_err <= 1'b0;
        end else if (w_accept && w_sel_oob) begin
            r_sel_err <= 1'b1;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign sel_err   = r_sel_err;

endmodule
`default_nettype wire

// File: tb/tb_sel_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_sel_pipe_reg
// Description : Directed and random-traffic self-checking bench for
//               sel_pipe_reg. Expectations follow SEL_PIPE_REG_SKID_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sel_pipe_reg;

`ifdef SEL_PIPE_REG_SKID_EN
    localparam bit c_SKID = 1'b1;
`else
    localparam bit c_SKID = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] in_bus;
    logic [1:0]   sel;
    logic         in_valid;
    logic         out_ready;
    logic         flush;

    logic         in_ready,  out_valid,  sel_err;
    logic [31:0]  out_data;
    logic         in_ready3, out_valid3, sel_err3;
    logic [31:0]  out_data3;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    sel_pipe_reg #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) u_dut (
        .clk(clk), .reset(reset), .in_bus(in_bus), .sel(sel),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
        .sel_err(sel_err)
    );

    sel_pipe_reg #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) u_dut3 (
        .clk(clk), .reset(reset), .in_bus(in_bus[95:0]), .sel(sel),
        .in_valid(in_valid), .in_ready(in_ready3), .out_data(out_data3),
        .out_valid(out_valid3), .out_ready(out_ready), .flush(flush),
        .sel_err(sel_err3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bus(input logic [31:0] c0, input logic [31:0] c1,
                           input logic [31:0] c2, input logic [31:0] c3);
        in_bus = {c3, c2, c1, c0};
    endtask

    initial begin
        logic [31:0] exp_q[$];
        logic [31:0] ch[4];
        int          cnt;
        bit          exp_rdy, pop, push;

        // ---------------- reset behaviour ----------------
        reset = 1'b1; in_valid = 1'b1; sel = 2'd0; out_ready = 1'b1; flush = 1'b0;
        set_bus(32'h11, 32'h22, 32'h33, 32'h44);
        tick(); tick();
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  out_data,       32'd0);
        chk("rst_sel_err",   32'(sel_err),   32'd0);
        tick();
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        tick();

        // ---------------- selection and latency ----------------
        in_valid = 1'b1; sel = 2'd2;
        @(negedge clk);
        chk("sel_idle_valid", 32'(out_valid), 32'd0);
        tick();
        sel = 2'd0;
        @(negedge clk);
        chk("sel2_valid", 32'(out_valid), 32'd1);
        chk("sel2_data",  out_data,       32'h33);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("sel0_valid", 32'(out_valid), 32'd1);
        chk("sel0_data",  out_data,       32'h11);
        tick();
        @(negedge clk);
        chk("sel_drained", 32'(out_valid), 32'd0);
        tick();

        // ---------------- stall ----------------
        out_ready = 1'b0; in_valid = 1'b1; sel = 2'd1;
        set_bus(32'h11, 32'hA5, 32'h33, 32'h44);
        @(negedge clk);
        chk("stall_rdy_empty", 32'(in_ready), 32'd1);
        tick();
        set_bus(32'h11, 32'h5A, 32'h33, 32'h44);
        @(negedge clk);
        chk("stall1_data",  out_data,        32'hA5);
        chk("stall1_valid", 32'(out_valid),  32'd1);
        chk("stall1_rdy",   32'(in_ready),   32'(c_SKID));
        tick();
        set_bus(32'h11, 32'h77, 32'h33, 32'h44);
        @(negedge clk);
        chk("stall2_data", out_data,       32'hA5);
        chk("stall2_rdy",  32'(in_ready),  32'd0);
        tick();
        @(negedge clk);
        chk("stall3_data",  out_data,       32'hA5);
        chk("stall3_valid", 32'(out_valid), 32'd1);
        chk("stall3_rdy",   32'(in_ready),  32'd0);
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("drain_a5", out_data, 32'hA5);
        tick();
        @(negedge clk);
        chk("drain2_valid", 32'(out_valid), 32'(c_SKID));
        if (c_SKID) chk("drain2_data", out_data, 32'h5A);
        tick();
        @(negedge clk);
        chk("drain_empty", 32'(out_valid), 32'd0);
        tick();

        // ---------------- flush ----------------
        out_ready = 1'b0; in_valid = 1'b1; sel = 2'd1;
        set_bus(32'h11, 32'hB1, 32'h33, 32'h44);
        tick();
        set_bus(32'h11, 32'hB2, 32'h33, 32'h44);
        tick();
        flush = 1'b1;
        set_bus(32'h11, 32'hF0, 32'h33, 32'h44);
        @(negedge clk);
        chk("flush_rdy", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_data_held", out_data, 32'hB1);
        tick();
        @(negedge clk);
        chk("flush_valid2", 32'(out_valid), 32'd0);
        tick();

        // ---------------- out-of-range select (NUM_IN=3) ----------------
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_bus(32'h11, 32'h22, 32'h33, 32'h44);
        in_valid = 1'b1; sel = 2'd1; out_ready = 1'b1;
        tick();
        sel = 2'd3;
        @(negedge clk);
        chk("oob_prev_data", out_data3,       32'h22);
        chk("oob_err_before", 32'(sel_err3),  32'd0);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("oob_data",    out_data3,        32'd0);
        chk("oob_valid",   32'(out_valid3),  32'd1);
        chk("oob_err",     32'(sel_err3),    32'd1);
        chk("inrange_data", out_data,        32'h44);
        chk("inrange_err", 32'(sel_err),     32'd0);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("oob_err_flush", 32'(sel_err3), 32'd1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("oob_err_reset", 32'(sel_err3), 32'd0);
        tick();

        // ---------------- random traffic ----------------
        cnt = 0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            for (int k = 0; k < 4; k++) ch[k] = $urandom;
            in_bus    = {ch[3], ch[2], ch[1], ch[0]};
            sel       = 2'($urandom_range(0, 3));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            exp_rdy   = c_SKID ? (cnt < 2) : (cnt == 0 || out_ready);
            @(negedge clk);
            chk("rnd_in_ready",  32'(in_ready),  32'(exp_rdy));
            chk("rnd_out_valid", 32'(out_valid), 32'(cnt > 0));
            pop  = (cnt > 0) && out_ready;
            push = in_valid && exp_rdy;
            if (pop) begin
                chk("rnd_out_data", out_data, exp_q[0]);
                void'(exp_q.pop_front());
            end
            if (push) exp_q.push_back(ch[sel]);
            cnt = cnt - int'(pop) + int'(push);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int d = 0; d < 4; d++) begin
            @(negedge clk);
            chk("drain_out_valid", 32'(out_valid), 32'(cnt > 0));
            if (cnt > 0) begin
                chk("drain_out_data", out_data, exp_q[0]);
                void'(exp_q.pop_front());
                cnt--;
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
